// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between fetch and data ports; data first, fetch wins after STARVE_LIMIT blocked grants.
// Latency: addr_ok in the grant cycle, mem_req from the next cycle, owner's data_ok combinational with mem_data_ok.
// Backpressure: one outstanding transaction; requesters hold until addr_ok, no grant outside IDLE.
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ADDR, WAIT, LOCAL} state_t;
    typedef enum logic {OWN_INST, OWN_DATA} owner_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state;
    owner_t      owner;
    logic        lat_wr;
    logic [3:0]  lat_wstrb;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  starve_cnt;
    logic        grant_inst;
    logic        grant_data;
    logic        zero_wr;
    logic        bus_done;

    // Grants are suppressed while reset is asserted so no handshake is lost to a reset edge.
    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (resetn && state == IDLE) begin
            grant_inst = inst_req && (!data_req || starve_cnt == LIMIT);
            grant_data = data_req && !grant_inst;
        end
    end

    assign zero_wr      = data_wr && (data_wstrb == 4'b0000);
    assign bus_done     = resetn && (state == WAIT) && mem_data_ok;

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;
    assign inst_data_ok = bus_done && (owner == OWN_INST);
    assign data_data_ok = (bus_done && (owner == OWN_DATA)) || (resetn && state == LOCAL);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    assign mem_req      = (state == ADDR);
    assign mem_wr       = lat_wr;
    assign mem_wstrb    = lat_wstrb;
    assign mem_addr     = lat_addr;
    assign mem_wdata    = lat_wdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            owner      <= OWN_INST;
            lat_wr     <= 1'b0;
            lat_wstrb  <= 4'b0000;
            lat_addr   <= 32'h0;
            lat_wdata  <= 32'h0;
            starve_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_inst) begin
                        owner      <= OWN_INST;
                        lat_wr     <= 1'b0;
                        lat_wstrb  <= 4'b0000;
                        lat_addr   <= inst_addr;
                        lat_wdata  <= 32'h0;
                        starve_cnt <= 4'd0;
                        state      <= ADDR;
                    end else if (grant_data) begin
                        owner      <= OWN_DATA;
                        lat_wr     <= data_wr;
                        lat_wstrb  <= data_wstrb;
                        lat_addr   <= data_addr;
                        lat_wdata  <= data_wdata;
                        if (inst_req && starve_cnt < LIMIT)
                            starve_cnt <= starve_cnt + 4'd1;
                        // A write with no enabled bytes completes locally without a bus cycle.
                        state      <= zero_wr ? LOCAL : ADDR;
                    end
                end
                ADDR:    if (mem_addr_ok) state <= WAIT;
                WAIT:    if (mem_data_ok) state <= IDLE;
                LOCAL:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random traffic checked against a transaction-level model.
module tb_mem_bus_arbiter;
    localparam int LIMIT = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: one open transaction at a time, tracked as flags plus the captured request.
    bit          m_open, m_local, m_acc, m_inst;
    logic        m_wr;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr, m_wdata;
    int          m_starve;

    initial begin
        m_open = 0; m_local = 0; m_acc = 0; m_inst = 0; m_starve = 0;
        m_wr = 0; m_wstrb = 0; m_addr = 0; m_wdata = 0;
        forever begin
            bit g_i, g_d, e_bus;
            @(negedge clk);
            g_i = !m_open && inst_req && (!data_req || m_starve == LIMIT);
            g_d = !m_open && data_req && !g_i;
            e_bus = m_open && m_acc && mem_data_ok;
            if (resetn) begin
                chk("m_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'({g_i, g_d}));
                chk("m_data_ok", 32'({inst_data_ok, data_data_ok}),
                    32'({e_bus && m_inst, (m_open && m_local) || (e_bus && !m_inst)}));
                chk("m_mem_req", 32'(mem_req), 32'(m_open && !m_local && !m_acc));
                if (m_open && !m_local && !m_acc) begin
                    chk("m_mem_addr", mem_addr, m_addr);
                    chk("m_mem_wr_strb", 32'({mem_wr, mem_wstrb}), 32'({m_wr, m_wstrb}));
                    if (m_wr) chk("m_mem_wdata", mem_wdata, m_wdata);
                end
                if (e_bus && m_inst)  chk("m_inst_rdata", inst_rdata, mem_rdata);
                if (e_bus && !m_inst) chk("m_data_rdata", data_rdata, mem_rdata);
            end
            if (!resetn) begin
                m_open = 0; m_local = 0; m_acc = 0; m_starve = 0;
            end else if (m_open) begin
                if (m_local)          m_open = 0;
                else if (!m_acc)      m_acc = mem_addr_ok;
                else if (mem_data_ok) m_open = 0;
            end else if (g_i || g_d) begin
                m_open  = 1;
                m_acc   = 0;
                m_inst  = g_i;
                m_wr    = g_d && data_wr;
                m_wstrb = g_d ? data_wstrb : 4'b0000;
                m_addr  = g_i ? inst_addr : data_addr;
                m_wdata = data_wdata;
                m_local = g_d && data_wr && data_wstrb == 4'b0000;
                if (g_i)           m_starve = 0;
                else if (inst_req) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
            end
        end
    end

    bit i_ack, d_ack, hold_req, resp_pend;
    int resp_dly;

    // Start of a cycle: pulse inputs fall, requesters that were accepted drop their request.
    task automatic nxt();
        @(posedge clk);
        #1;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        if (i_ack && !hold_req) inst_req = 1'b0;
        if (d_ack && !hold_req) data_req = 1'b0;
    endtask

    task automatic smp();
        @(negedge clk);
        i_ack = inst_addr_ok;
        d_ack = data_addr_ok;
    endtask

    task automatic serve(input logic [31:0] rd);
        nxt(); mem_addr_ok = 1'b1; smp();
        nxt(); mem_data_ok = 1'b1; mem_rdata = rd; smp();
    endtask

    task automatic do_reset();
        nxt(); resetn = 1'b0; inst_req = 1'b0; data_req = 1'b0; smp();
        nxt(); resetn = 1'b1; smp();
    endtask

    initial begin
        resetn = 1'b0; inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0;
        data_wstrb = 0; data_addr = 0; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
        i_ack = 0; d_ack = 0; hold_req = 0; resp_pend = 0; resp_dly = 0;
        do_reset();
        chk("rst_ctrl", 32'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, mem_req, mem_wr}), 32'd0);
        chk("rst_fields", mem_addr | mem_wdata | 32'(mem_wstrb), 32'd0);

        // Single fetch
        nxt(); inst_req = 1; inst_addr = 32'hBFC0_0000; smp();
        chk("t1_grant", 32'({inst_addr_ok, data_addr_ok}), 32'b10);
        nxt(); mem_addr_ok = 1; smp();
        chk("t1_mem_req", 32'(mem_req), 32'd1);
        chk("t1_mem_addr", mem_addr, 32'hBFC0_0000);
        chk("t1_mem_wr", 32'(mem_wr), 32'd0);
        nxt(); smp();
        chk("t1_wait", 32'({mem_req, inst_data_ok}), 32'd0);
        nxt(); mem_data_ok = 1; mem_rdata = 32'h2401_0001; smp();
        chk("t1_data_ok", 32'({inst_data_ok, data_data_ok}), 32'b10);
        chk("t1_rdata", inst_rdata, 32'h2401_0001);

        // Simultaneous requests: data first, fetch right after
        nxt();
        inst_req = 1; inst_addr = 32'hBFC0_0004;
        data_req = 1; data_wr = 1; data_addr = 32'h1000_0004;
        data_wstrb = 4'b1100; data_wdata = 32'hABCD_0000;
        smp();
        chk("t2_grant", 32'({inst_addr_ok, data_addr_ok}), 32'b01);
        nxt(); mem_addr_ok = 1; smp();
        chk("t2_wstrb", 32'(mem_wstrb), 32'b1100);
        chk("t2_wdata", mem_wdata, 32'hABCD_0000);
        chk("t2_addr", mem_addr, 32'h1000_0004);
        nxt(); mem_data_ok = 1; smp();
        chk("t2_data_ok", 32'({inst_data_ok, data_data_ok}), 32'b01);
        nxt(); smp();
        chk("t2_fetch_next", 32'({inst_addr_ok, data_addr_ok}), 32'b10);
        serve(32'h0000_0013);

        // Starvation guard with both requests held
        do_reset();
        hold_req = 1;
        for (int g = 0; g < 6; g++) begin
            nxt();
            if (g == 0) begin
                inst_req = 1; inst_addr = 32'hBFC0_0100;
                data_req = 1; data_wr = 0; data_wstrb = 4'b1111; data_addr = 32'h1000_0100;
            end
            smp();
            chk("t3_order", 32'({inst_addr_ok, data_addr_ok}), (g % 3 == 2) ? 32'b10 : 32'b01);
            serve($urandom);
        end
        hold_req = 0;
        nxt(); inst_req = 0; data_req = 0; smp();

        // Zero-strobe write completes locally
        nxt(); data_req = 1; data_wr = 1; data_wstrb = 4'b0000;
        data_addr = 32'h3000_0000; data_wdata = 32'hFFFF_FFFF; smp();
        chk("t4_grant", 32'({data_addr_ok, mem_req}), 32'b10);
        nxt(); smp();
        chk("t4_done", 32'({data_data_ok, mem_req}), 32'b10);
        nxt(); inst_req = 1; inst_addr = 32'hBFC0_0200; smp();
        chk("t4_next_grant", 32'({inst_addr_ok, data_data_ok, mem_req}), 32'b100);
        serve(32'h0);

        // Bus backpressure: request fields frozen, no other grant
        nxt(); data_req = 1; data_wr = 1; data_wstrb = 4'b0011;
        data_addr = 32'h2000_0010; data_wdata = 32'h0000_5A5A; smp();
        chk("t5_grant", 32'(data_addr_ok), 32'd1);
        for (int c = 0; c < 5; c++) begin
            nxt(); inst_req = 1; inst_addr = 32'hBFC0_0300; smp();
            chk("t5_hold_req", 32'({mem_req, inst_addr_ok, data_addr_ok}), 32'b100);
            chk("t5_hold_addr", mem_addr, 32'h2000_0010);
            chk("t5_hold_wdata", mem_wdata, 32'h0000_5A5A);
            chk("t5_hold_wstrb", 32'(mem_wstrb), 32'b0011);
        end
        serve(32'h0);
        chk("t5_done", 32'(data_data_ok), 32'd1);
        nxt(); smp();
        chk("t5_fetch_grant", 32'(inst_addr_ok), 32'd1);
        serve(32'h0);

        // Reset while waiting for the bus response
        do_reset();
        nxt(); inst_req = 1; inst_addr = 32'hBFC0_0400; smp();
        nxt(); mem_addr_ok = 1; smp();
        nxt(); resetn = 0; smp();
        nxt(); resetn = 1; mem_data_ok = 1; mem_rdata = 32'hDEAD_BEEF; smp();
        chk("t6_ctrl", 32'({inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, mem_req, mem_wr}), 32'd0);
        chk("t6_fields", mem_addr | mem_wdata | 32'(mem_wstrb), 32'd0);
        nxt(); inst_req = 1; inst_addr = 32'hBFC0_0500; smp();
        chk("t6_regrant", 32'(inst_addr_ok), 32'd1);
        serve(32'h1234_5678);
        chk("t6_data_ok", 32'(inst_data_ok), 32'd1);
        chk("t6_rdata", inst_rdata, 32'h1234_5678);

        // Random traffic, noisy bus handshakes and occasional resets
        for (int c = 0; c < 4000; c++) begin
            nxt();
            resetn = ($urandom_range(0, 299) != 0);
            if (!inst_req) begin
                inst_req  = ($urandom_range(0, 3) != 0);
                inst_addr = $urandom;
            end
            if (!data_req) begin
                data_req   = ($urandom_range(0, 2) != 0);
                data_wr    = 1'($urandom);
                data_wstrb = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
                data_addr  = $urandom;
                data_wdata = $urandom;
            end
            if (resp_pend) begin
                if (resp_dly == 0) begin
                    mem_data_ok = 1;
                    resp_pend   = 0;
                end else begin
                    resp_dly--;
                end
            end else begin
                mem_data_ok = ($urandom_range(0, 7) == 0);
            end
            mem_addr_ok = ($urandom_range(0, 4) < 2);
            mem_rdata   = $urandom;
            smp();
            if (!resetn) resp_pend = 0;
            else if (mem_req && mem_addr_ok) begin
                resp_pend = 1;
                resp_dly  = $urandom_range(0, 3);
            end
        end
        nxt(); resetn = 1; inst_req = 0; data_req = 0; smp();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single SRAM-like data bus between the instruction-fetch port and the MEM-stage data port of the CPU. Data requests come from the store/load datapath: byte strobes, address and aligned write data as produced by the memory input mux. Read data is returned to the port that owns the transaction, for the load-result mux. The block allows one outstanding bus transaction, gives priority to data accesses, and includes a starvation guard for fetch.

## Interface

**Parameters**
- `STARVE_LIMIT`, default 4: consecutive fetch-blocked data grants after which fetch wins. Legal range 1..15.

**Ports**
- `clk` in 1: sole clock, rising edge.
- `resetn` in 1: synchronous, active-low reset. One clock; reset is synchronous and active-low.
- `inst_req` in 1: fetch read request.
- `inst_addr` in 32: fetch address.
- `inst_addr_ok` out 1: fetch request accepted this cycle.
- `inst_data_ok` out 1: fetch data valid this cycle.
- `inst_rdata` out 32: fetch read data.
- `data_req` in 1: data request.
- `data_wr` in 1: 1 = write, 0 = read.
- `data_wstrb` in 4: byte enables for writes.
- `data_addr` in 32: data address.
- `data_wdata` in 32: lane-aligned write data.
- `data_addr_ok` out 1: data request accepted this cycle.
- `data_data_ok` out 1: data transaction complete; read data valid.
- `data_rdata` out 32: data read data.
- `mem_req` out 1: bus request.
- `mem_wr` out 1: bus write.
- `mem_wstrb` out 4: bus byte enables.
- `mem_addr` out 32: bus address.
- `mem_wdata` out 32: bus write data.
- `mem_addr_ok` in 1: bus accepted request.
- `mem_data_ok` in 1: bus response valid.
- `mem_rdata` in 32: bus read data.

## Operation

**States:** IDLE, ADDR, WAIT, LOCAL. The owner register holds INST or DATA.

**IDLE**
- Arbitrate among `inst_req` and `data_req`.
- Data wins, except when `starve_cnt == STARVE_LIMIT` with `inst_req` high; then fetch wins.
- The granted port's `*_addr_ok` is asserted combinationally in that same cycle; the other port's is held 0.
- On grant, latch wr, wstrb, addr, wdata and owner.
  - Fetch latches wr=0, wstrb=0.
- Next state is ADDR.
- Exception: a data write with `data_wstrb == 4'b0000` is accepted (`data_addr_ok=1`) but goes to LOCAL and never touches the bus.

**ADDR**
- `mem_req=1`; `mem_*` are driven from the latched fields and stay stable until `mem_addr_ok`.
- `mem_addr_ok=1` moves to WAIT.

**WAIT**
- `mem_req=0`.
- `mem_data_ok=1` asserts the owner's `*_data_ok` combinationally that same cycle, then moves to IDLE.

**LOCAL**
- `data_data_ok=1` for exactly one cycle, then IDLE.

**Read data**
- `inst_rdata` and `data_rdata` are both wired to `mem_rdata`. They are valid only when the matching `*_data_ok` is 1.

**Starvation counter** (`starve_cnt`, 4 bits)
- +1 on each IDLE grant to data while `inst_req=1`.
- Cleared on each fetch grant.
- Saturates at `STARVE_LIMIT`.

**Ignored inputs**
- `mem_data_ok` in IDLE, ADDR or LOCAL is ignored; no `*_data_ok` is produced.
- `mem_addr_ok` outside ADDR is ignored.

**Requester rule**
- A requester must hold req and its fields stable until its `addr_ok`. The arbiter samples them only in IDLE.

## Timing

**Reset** (`resetn=0` at a rising edge)
- Next cycle: state=IDLE, `starve_cnt=0`, owner=INST, latched fields=0.
- All outputs are 0: `mem_req`, all `*_addr_ok` and `*_data_ok`, and the `mem_*` fields.
- A reset during ADDR or WAIT abandons the transaction. No `*_data_ok` is issued for it.

**Latency**
- Grant in cycle N (IDLE) → `mem_req` from N+1.
- Minimum completion: `mem_addr_ok` at N+1, `mem_data_ok` at N+2 → `*_data_ok` at N+2.
- Back-to-back: the next grant is possible at N+3, one IDLE cycle after completion.
- Zero-strobe write: `data_addr_ok` at N, `data_data_ok` at N+1, next grant at N+2.

**Handshake**
- At most one `*_addr_ok` and at most one `*_data_ok` may be high per cycle.
- No new grant is made while in ADDR, WAIT or LOCAL. Requests wait; nothing is dropped.
- `mem_data_ok` from the bus comes at least one cycle after `mem_addr_ok`. This is a bus contract; the arbiter does not check it.

## Test plan

1. **Single fetch.** `inst_req`, `inst_addr=0xBFC00000` at cycle 0; bus `mem_addr_ok` at cycle 1, `mem_data_ok` with rdata `0x24010001` at cycle 3.
   - Required: `inst_addr_ok` at cycle 0; `mem_addr=0xBFC00000`, `mem_wr=0` at cycle 1; `inst_data_ok=1` with `inst_rdata=0x24010001` at cycle 3.
2. **Simultaneous requests.** `inst_req` and `data_req` (write `0x1000_0004`, wstrb `4'b1100`, wdata `0xABCD0000`) together.
   - Required: `data_addr_ok` first; `mem_wstrb=1100`, `mem_wdata=0xABCD0000`.
   - Fetch is granted in the first IDLE after completion.
3. **Starvation, `STARVE_LIMIT=2`.** Both requests held high continuously; bus responds in minimum time.
   - Required grant order: D, D, I, D, D, I.
4. **Zero-strobe write.** `data_wr=1`, `data_wstrb=0` at cycle 0.
   - Required: `data_addr_ok` at cycle 0, `data_data_ok` at cycle 1, `mem_req` never asserted.
5. **Bus backpressure.** `mem_addr_ok` held low for 5 cycles.
   - Required: `mem_req`, `mem_addr`, `mem_wdata` and `mem_wstrb` constant for all 5 cycles; no new `addr_ok` to either port.
6. **Reset mid-transaction.** `resetn=0` for one cycle while in WAIT; `mem_data_ok` pulses on the following cycle.
   - Required: all outputs 0 after reset; no `*_data_ok`; a fresh fetch request is accepted normally afterwards.
